// File: rtl/regfile_pkg.sv
// Shared register-file geometry and helpers used by the register file and its write arbiter.
package regfile_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 2;
    localparam int unsigned NUM_REGS = 4;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic {
        SrcReq0 = 1'b0,
        SrcReq1 = 1'b1
    } src_e;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; grants are combinational and suppressed during reset.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                // Contended: favour whoever was not granted most recently.
                if (last_q == SrcReq1) begin
                    gnt0 = 1'b1;
                end else begin
                    gnt1 = 1'b1;
                end
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt0) begin
            last_d = SrcReq0;
        end else if (gnt1) begin
            last_d = SrcReq1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= SrcReq1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges two register-file write requesters onto one registered write port,
// counting cycles in which both requesters contend.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_wsrc,
    output logic [7:0]        conflict_cnt
);

    import regfile_pkg::*;

    logic gnt0;
    logic gnt1;
    logic xfer0;
    logic xfer1;

    logic              we_q,    we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    src_e              wsrc_q,  wsrc_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    rr_arbiter2 u_rr_arbiter2 (
        .clk   (clk),
        .reset (reset),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign xfer0      = req0_valid & gnt0;
    assign xfer1      = req1_valid & gnt1;

    always_comb begin
        we_d    = xfer0 | xfer1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wsrc_d  = wsrc_q;
        if (xfer1) begin
            waddr_d = req1_addr;
            wdata_d = req1_data;
            wsrc_d  = SrcReq1;
        end else if (xfer0) begin
            waddr_d = req0_addr;
            wdata_d = req0_data;
            wsrc_d  = SrcReq0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wsrc_q  <= SrcReq0;
            cnt_q   <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wsrc_q  <= wsrc_d;
            cnt_q   <= cnt_d;
        end
    end

    // A write accepted just before reset must never reach the register file.
    assign rf_we        = we_q & ~reset;
    assign rf_waddr     = waddr_q;
    assign rf_wdata     = wdata_q;
    assign rf_wsrc      = wsrc_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected writes and checks, a negedge monitor compares.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
        logic       src;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       r0v, r1v;
    logic [1:0] r0a, r1a;
    logic [7:0] r0d, r1d;
    logic       r0rdy, r1rdy;
    logic       rf_we;
    logic [1:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic       rf_wsrc;
    logic [7:0] conflict_cnt;

    always #5 clk = ~clk;

    regfile_write_arbiter #(
        .DATA_W (8),
        .ADDR_W (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (r0v),
        .req0_addr    (r0a),
        .req0_data    (r0d),
        .req0_ready   (r0rdy),
        .req1_valid   (r1v),
        .req1_addr    (r1a),
        .req1_data    (r1d),
        .req1_ready   (r1rdy),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .rf_wsrc      (rf_wsrc),
        .conflict_cnt (conflict_cnt)
    );

    wr_t        sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] rf_model [4];

    // Check requests, owned by stimulus and consumed by the monitor.
    logic        rdy_chk, exp_rdy0, exp_rdy1;
    logic        cnt_chk;
    logic [7:0]  exp_cnt;
    logic        out_chk;
    logic [11:0] exp_out;
    logic        we0_chk;
    logic        reg_chk;
    logic [1:0]  reg_idx;
    logic [7:0]  exp_reg;
    logic        done;

    // Contended burst: inputs per cycle and hand-derived write sequence.
    logic [7:0] t_d0 [4]    = '{8'h01, 8'h02, 8'h02, 8'h03};
    logic [7:0] t_d1 [4]    = '{8'h81, 8'h81, 8'h82, 8'h82};
    logic       t_win [4]   = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] t_wdata [4] = '{8'h01, 8'h81, 8'h02, 8'h82};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        chk("ready_onehot", 32'(r0rdy & r1rdy), 32'd0);
        if (rf_we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_write", {21'd0, rf_waddr, rf_wdata, rf_wsrc}, 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("write", {21'd0, rf_waddr, rf_wdata, rf_wsrc}, 32'(e));
            end
            rf_model[rf_waddr] = rf_wdata;
        end
        if (rdy_chk)  chk("ready", {30'd0, r0rdy, r1rdy}, {30'd0, exp_rdy0, exp_rdy1});
        if (cnt_chk)  chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
        if (out_chk)  chk("outputs", {20'd0, rf_we, rf_waddr, rf_wdata, rf_wsrc}, 32'(exp_out));
        if (we0_chk)  chk("we_gated", 32'(rf_we), 32'd0);
        if (reg_chk)  chk("reg_final", 32'(rf_model[reg_idx]), 32'(exp_reg));
        if (done) begin
            chk("sb_empty", 32'(sb_q.size()), 32'd0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        rdy_chk = 1'b0;
        cnt_chk = 1'b0;
        out_chk = 1'b0;
        we0_chk = 1'b0;
        reg_chk = 1'b0;
    endtask

    task automatic exp_ready(input logic a, input logic b);
        rdy_chk  = 1'b1;
        exp_rdy0 = a;
        exp_rdy1 = b;
    endtask

    task automatic push(input logic [1:0] a, input logic [7:0] d, input logic s);
        wr_t w;
        w = {a, d, s};
        sb_q.push_back(w);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        r0v   = 1'b0;
        r1v   = 1'b0;
        cycle();
        cycle();
        reset   = 1'b0;
        out_chk = 1'b1;
        exp_out = '0;
        cnt_chk = 1'b1;
        exp_cnt = 8'd0;
    endtask

    initial begin
        reset = 1'b1;
        r0v = 1'b0; r1v = 1'b0;
        r0a = '0;   r1a = '0;
        r0d = '0;   r1d = '0;
        rdy_chk = 1'b0; exp_rdy0 = 1'b0; exp_rdy1 = 1'b0;
        cnt_chk = 1'b0; exp_cnt = '0;
        out_chk = 1'b0; exp_out = '0;
        we0_chk = 1'b0;
        reg_chk = 1'b0; reg_idx = '0; exp_reg = '0;
        done = 1'b0;
        for (int i = 0; i < 4; i++) rf_model[i] = '0;
        cycle();

        // Requests during reset: no ready, no transfer, no counting.
        r0v = 1'b1; r1v = 1'b1;
        exp_ready(1'b0, 1'b0);
        cycle();
        cnt_chk = 1'b1; exp_cnt = 8'd0;
        r0v = 1'b0; r1v = 1'b0;
        cycle();

        // Single requester, latency 1, then hold with rf_we low.
        do_reset();
        r0v = 1'b1; r0a = 2'd2; r0d = 8'h5A;
        exp_ready(1'b1, 1'b0);
        push(2'd2, 8'h5A, 1'b0);
        cycle();
        r0v = 1'b0;
        cycle();
        cycle();
        out_chk = 1'b1; exp_out = {1'b0, 2'd2, 8'h5A, 1'b0};
        cycle();

        // Contention straight out of reset goes to req0 first.
        do_reset();
        r0v = 1'b1; r0a = 2'd1; r0d = 8'h11;
        r1v = 1'b1; r1a = 2'd3; r1d = 8'h33;
        exp_ready(1'b1, 1'b0);
        push(2'd1, 8'h11, 1'b0);
        cycle();
        r0v = 1'b0;
        exp_ready(1'b0, 1'b1);
        push(2'd3, 8'h33, 1'b1);
        cycle();
        r1v = 1'b0;
        cnt_chk = 1'b1; exp_cnt = 8'd1;
        cycle();
        cycle();

        // Sustained contention alternates at full throughput.
        do_reset();
        r0v = 1'b1; r0a = 2'd0;
        r1v = 1'b1; r1a = 2'd1;
        for (int i = 0; i < 4; i++) begin
            r0d = t_d0[i];
            r1d = t_d1[i];
            exp_ready(~t_win[i], t_win[i]);
            push(t_win[i] ? 2'd1 : 2'd0, t_wdata[i], t_win[i]);
            cycle();
        end
        r0v = 1'b0; r1v = 1'b0;
        cnt_chk = 1'b1; exp_cnt = 8'd4;
        cycle();
        cycle();

        // Same address from both: later write wins.
        do_reset();
        r0v = 1'b1; r0a = 2'd0; r0d = 8'hAA;
        r1v = 1'b1; r1a = 2'd0; r1d = 8'hBB;
        exp_ready(1'b1, 1'b0);
        push(2'd0, 8'hAA, 1'b0);
        cycle();
        r0v = 1'b0;
        exp_ready(1'b0, 1'b1);
        push(2'd0, 8'hBB, 1'b1);
        cycle();
        r1v = 1'b0;
        cycle();
        cycle();
        reg_chk = 1'b1; reg_idx = 2'd0; exp_reg = 8'hBB;
        cycle();

        // Counter saturation under 300 contended cycles.
        do_reset();
        r0v = 1'b1; r0a = 2'd2; r0d = 8'hC3;
        r1v = 1'b1; r1a = 2'd1; r1d = 8'h3C;
        for (int i = 0; i < 300; i++) begin
            exp_ready(i % 2 == 0, i % 2 == 1);
            if (i % 2 == 0) push(2'd2, 8'hC3, 1'b0);
            else            push(2'd1, 8'h3C, 1'b1);
            cycle();
            if (i == 253) begin cnt_chk = 1'b1; exp_cnt = 8'd254; end
            if (i == 254) begin cnt_chk = 1'b1; exp_cnt = 8'd255; end
        end
        cnt_chk = 1'b1; exp_cnt = 8'd255;
        r0v = 1'b0; r1v = 1'b0;
        cycle();
        cycle();

        // Reset right after a req1 transfer discards the write.
        do_reset();
        r1v = 1'b1; r1a = 2'd3; r1d = 8'h77;
        exp_ready(1'b0, 1'b1);
        cycle();
        reset = 1'b1;
        we0_chk = 1'b1;
        exp_ready(1'b0, 1'b0);
        cycle();
        reset = 1'b0;
        r1v = 1'b0;
        out_chk = 1'b1; exp_out = '0;
        cnt_chk = 1'b1; exp_cnt = 8'd0;
        cycle();
        r0v = 1'b1; r0a = 2'd0; r0d = 8'h12;
        r1v = 1'b1; r1a = 2'd1; r1d = 8'h34;
        exp_ready(1'b1, 1'b0);
        push(2'd0, 8'h12, 1'b0);
        cycle();
        r0v = 1'b0;
        exp_ready(1'b0, 1'b1);
        push(2'd1, 8'h34, 1'b1);
        cycle();
        r1v = 1'b0;
        cycle();
        cycle();
        done = 1'b1;
        cycle();
        cycle();
    end

endmodule
